// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-bus arbiter: FSM encoding,
// transfer direction constants and counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot winner selection over CHANNELS requesters, with optional fixed
// priority for channel 0 and a round-robin pointer advanced on each grant.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter bit CPU_PRIORITY = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_req,
    input  logic                i_grant_en,
    output logic [CHANNELS-1:0] o_grant
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // In CPU-priority mode channel 0 never takes a round-robin slot.
    localparam logic [PTR_W-1:0] WRAP_PTR =
        (CPU_PRIORITY && CHANNELS > 1) ? PTR_W'(1) : '0;

    logic [PTR_W-1:0]    r_ptr;
    logic [CHANNELS-1:0] w_elig;
    logic [CHANNELS-1:0] w_mask;
    logic [CHANNELS-1:0] w_src;
    logic [CHANNELS-1:0] w_onehot;
    logic [PTR_W-1:0]    w_idx;
    logic                w_found;

    always_comb begin
        w_elig   = i_req;
        w_mask   = '0;
        w_onehot = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        if (CPU_PRIORITY) begin
            w_elig[0] = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            w_mask[i] = (PTR_W'(i) >= r_ptr);
        end
        // Requesters at or above the pointer first, then wrap to the rest.
        w_src = ((w_elig & w_mask) != '0) ? (w_elig & w_mask) : w_elig;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_src[i] && !w_found) begin
                w_onehot[i] = 1'b1;
                w_idx       = PTR_W'(i);
                w_found     = 1'b1;
            end
        end
        if (CPU_PRIORITY && i_req[0]) begin
            w_onehot    = '0;
            w_onehot[0] = 1'b1;
            w_idx       = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
        end else if (i_grant_en) begin
            if (w_idx == PTR_W'(CHANNELS - 1)) begin
                r_ptr <= WRAP_PTR;
            end else begin
                r_ptr <= w_idx + PTR_W'(1);
            end
        end
    end

    assign o_grant = w_onehot;

endmodule

// File: rtl/mem_arbiter.sv
// Memory-bus arbiter and access sequencer: grants one master, drives the
// registered bus strobes through wait states, ready handshake and timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH_MAIN   = 8,
    parameter int WIDTH_AX     = 16,
    parameter int CHANNELS     = 2,
    parameter int WAIT_STATES  = 1,
    parameter bit CPU_PRIORITY = 1'b1,
    parameter int TIMEOUT      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            dir,
    input  logic [CHANNELS*WIDTH_AX-1:0]   addr,
    input  logic [CHANNELS*WIDTH_MAIN-1:0] wdata,
    output logic [CHANNELS-1:0]            ack,
    output logic                           err,
    output logic [WIDTH_MAIN-1:0]          rdata,
    output logic [CHANNELS-1:0]            grant,
    output logic                           busy,
    output logic [WIDTH_AX-1:0]            mem_addr,
    output logic [WIDTH_MAIN-1:0]          mem_wdata,
    output logic                           mem_re,
    output logic                           mem_we,
    input  logic [WIDTH_MAIN-1:0]          mem_rdata,
    input  logic                           mem_ready,
    output logic [1:0]                     dbg_state
);
    localparam int CNT_W  = cnt_width(WAIT_STATES);
    localparam int TCNT_W = cnt_width(TIMEOUT);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [TCNT_W-1:0]     r_tcnt;
    logic                  r_dir;
    logic [CHANNELS-1:0]   r_ack;
    logic                  r_err;
    logic [WIDTH_MAIN-1:0] r_rdata;
    logic [CHANNELS-1:0]   r_grant;
    logic [WIDTH_AX-1:0]   r_mem_addr;
    logic [WIDTH_MAIN-1:0] r_mem_wdata;
    logic                  r_mem_re;
    logic                  r_mem_we;

    logic                  w_start;
    logic [CHANNELS-1:0]   w_grant;
    logic [WIDTH_AX-1:0]   w_addr_sel;
    logic [WIDTH_MAIN-1:0] w_wdata_sel;
    logic                  w_dir_sel;

    assign w_start = (r_state == IDLE) && (req != '0);

    rr_arbiter #(
        .CHANNELS     (CHANNELS),
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_rr (
        .i_clk      (clk),
        .i_reset_n  (reset),
        .i_req      (req),
        .i_grant_en (w_start),
        .o_grant    (w_grant)
    );

    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_dir_sel   = DIR_WRITE;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_addr_sel  = addr[i*WIDTH_AX +: WIDTH_AX];
                w_wdata_sel = wdata[i*WIDTH_MAIN +: WIDTH_MAIN];
                w_dir_sel   = dir[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_dir       <= DIR_WRITE;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_grant     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= ACCESS;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                        r_dir       <= w_dir_sel;
                        r_mem_re    <= (w_dir_sel == DIR_READ);
                        r_mem_we    <= (w_dir_sel == DIR_WRITE);
                        r_grant     <= w_grant;
                        r_cnt       <= CNT_W'(WAIT_STATES);
                        r_tcnt      <= '0;
                    end
                end
                ACCESS: begin
                    // Ready is only looked at once the wait states have run out.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (mem_ready) begin
                        if (r_dir == DIR_READ) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack    <= r_grant;
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= DONE;
                    end else if (TIMEOUT != 0) begin
                        if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                            if (r_dir == DIR_READ) begin
                                r_rdata <= '1;
                            end
                            r_ack    <= r_grant;
                            r_err    <= 1'b1;
                            r_mem_re <= 1'b0;
                            r_mem_we <= 1'b0;
                            r_state  <= DONE;
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign grant     = r_grant;
    assign busy      = (r_state != IDLE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (CPU-priority with a wait state, and
// round-robin with a timeout) checked against a transaction-level model.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic [2:0]  req_a, req_b, dir;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    logic [2:0]  ack_a, grant_a, ack_b, grant_b;
    logic        err_a, busy_a, re_a, we_a, err_b, busy_b, re_b, we_b;
    logic [7:0]  rdata_a, mwd_a, rdata_b, mwd_b;
    logic [15:0] maddr_a, maddr_b;
    logic [1:0]  st_a, st_b;

    logic [2:0]  o_ack, o_grant;
    logic        o_err, o_busy, o_re, o_we;
    logic [7:0]  o_rdata, o_wdata;
    logic [15:0] o_addr;

    int          sel;
    int          checks;
    int          errors;
    int          ptr_m [2];
    logic [7:0]  rdata_m [2];

    mem_arbiter #(.WIDTH_MAIN(8), .WIDTH_AX(16), .CHANNELS(3), .WAIT_STATES(1),
                  .CPU_PRIORITY(1'b1), .TIMEOUT(0)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .dir(dir), .addr(addr), .wdata(wdata),
        .ack(ack_a), .err(err_a), .rdata(rdata_a), .grant(grant_a), .busy(busy_a),
        .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_re(re_a), .mem_we(we_a),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(st_a));

    mem_arbiter #(.WIDTH_MAIN(8), .WIDTH_AX(16), .CHANNELS(3), .WAIT_STATES(0),
                  .CPU_PRIORITY(1'b0), .TIMEOUT(4)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .dir(dir), .addr(addr), .wdata(wdata),
        .ack(ack_b), .err(err_b), .rdata(rdata_b), .grant(grant_b), .busy(busy_b),
        .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_re(re_b), .mem_we(we_b),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(st_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel == 0) begin
            o_ack = ack_a; o_grant = grant_a; o_err = err_a; o_busy = busy_a;
            o_re = re_a; o_we = we_a; o_rdata = rdata_a; o_wdata = mwd_a; o_addr = maddr_a;
        end else begin
            o_ack = ack_b; o_grant = grant_b; o_err = err_b; o_busy = busy_b;
            o_re = re_b; o_we = we_b; o_rdata = rdata_b; o_wdata = mwd_b; o_addr = maddr_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    // Reference arbitration: channel 0 first in priority mode, otherwise the
    // first requester found scanning upward from the pointer.
    function automatic int pick(input int s, input logic [2:0] r);
        int c;
        bit cp;
        cp = (s == 0);
        if (cp && r[0]) return 0;
        for (int i = 0; i < 3; i++) begin
            c = (ptr_m[s] + i) % 3;
            if (cp && c == 0) continue;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic advance_ptr(input int s, input int g);
        ptr_m[s] = (g + 1) % 3;
        if (s == 0 && ptr_m[s] == 0) ptr_m[s] = 1;
    endtask

    // One complete transaction starting from IDLE; called at a negedge.
    task automatic run_txn(input logic [2:0] reqs, input logic [2:0] dirs,
                           input logic [47:0] addrs, input logic [23:0] wds,
                           input logic [7:0] rd, input bit rnd_ready, input int rise);
        bit          rdy [40];
        int          w, c, wst, tmo;
        bit          to;
        logic        xdir;
        logic [15:0] xaddr;
        logic [7:0]  xwd, exp_rd;
        logic [2:0]  oh;
        wst = (sel == 0) ? 1 : 0;
        tmo = (sel == 0) ? 0 : 4;
        for (int k = 0; k < 40; k++) begin
            rdy[k] = rnd_ready ? ($urandom_range(0, 2) != 0) : (k >= rise);
        end
        // Completion edge: first ready edge after the wait states, or the timeout edge.
        c  = -1;
        to = 1'b0;
        for (int k = 1 + wst; k < 40; k++) begin
            if (c < 0) begin
                if (rdy[k]) c = k;
                else if (tmo != 0 && k == wst + tmo) begin c = k; to = 1'b1; end
            end
        end
        if (c < 0) c = 39;
        w = pick(sel, reqs);
        oh = 3'b001 << w;
        xdir = dirs[w[1:0]];
        xaddr = addrs[w*16 +: 16];
        xwd = wds[w*8 +: 8];
        dir = dirs; addr = addrs; wdata = wds; mem_rdata = rd; mem_ready = rdy[0];
        if (sel == 0) req_a = reqs; else req_b = reqs;
        @(negedge clk);
        advance_ptr(sel, w);
        chk("grant_start", o_grant, oh);
        chk("busy_start", o_busy, 1);
        chk("re_start", o_re, xdir);
        chk("we_start", o_we, !xdir);
        chk("addr_start", o_addr, xaddr);
        if (!xdir) chk("wdata_start", o_wdata, xwd);
        chk("ack_start", o_ack, 0);
        for (int k = 1; k <= c; k++) begin
            mem_ready = rdy[k];
            dir = 3'($urandom); addr = {$urandom, 16'($urandom)}; wdata = 24'($urandom);
            if (sel == 0) req_a = 3'($urandom); else req_b = 3'($urandom);
            @(negedge clk);
            if (k < c) begin
                chk("re_hold", o_re, xdir);
                chk("we_hold", o_we, !xdir);
                chk("addr_hold", o_addr, xaddr);
                chk("ack_hold", o_ack, 0);
            end
        end
        exp_rd = rdata_m[sel];
        if (xdir) exp_rd = to ? 8'hFF : rd;
        rdata_m[sel] = exp_rd;
        chk("ack_done", o_ack, oh);
        chk("err_done", o_err, to);
        chk("re_done", o_re, 0);
        chk("we_done", o_we, 0);
        chk("rdata_done", o_rdata, exp_rd);
        chk("grant_done", o_grant, oh);
        chk("busy_done", o_busy, 1);
        if (sel == 0) req_a = 3'b000; else req_b = 3'b000;
        @(negedge clk);
        chk("ack_idle", o_ack, 0);
        chk("err_idle", o_err, 0);
        chk("grant_idle", o_grant, 0);
        chk("busy_idle", o_busy, 0);
        chk("rdata_idle", o_rdata, rdata_m[sel]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rq;
        checks = 0; errors = 0; sel = 0;
        reset = 1'b0; req_a = '0; req_b = '0; dir = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        ptr_m[0] = 0; ptr_m[1] = 0; rdata_m[0] = '0; rdata_m[1] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            chk("rst_ack", o_ack, 0); chk("rst_err", o_err, 0);
            chk("rst_grant", o_grant, 0); chk("rst_busy", o_busy, 0);
            chk("rst_re", o_re, 0); chk("rst_we", o_we, 0);
            chk("rst_rdata", o_rdata, 0); chk("rst_addr", o_addr, 0);
        end
        sel = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed read on ch0 then write on ch1 (one wait state, ready high).
        run_txn(3'b001, 3'b001, {16'h0, 16'h0, 16'h1234}, 24'h0, 8'hA5, 1'b0, 0);
        run_txn(3'b010, 3'b000, {16'h0, 16'h00FF, 16'h0}, {8'h00, 8'h3C, 8'h00}, 8'h11, 1'b0, 0);

        // CPU priority: ch0 beats ch2 while requesting, then ch2 gets in.
        for (int i = 0; i < 3; i++)
            run_txn(3'b101, 3'($urandom), {$urandom, 16'($urandom)}, 24'($urandom), 8'($urandom), 1'b0, 0);
        run_txn(3'b100, 3'($urandom), {$urandom, 16'($urandom)}, 24'($urandom), 8'($urandom), 1'b0, 0);

        // Reset in the middle of an access aborts it with no ack.
        req_a = 3'b010; dir = 3'b010; addr = {$urandom, 16'($urandom)}; mem_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", o_busy, 1);
        chk("pre_rst_grant", o_grant, 3'b010);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_re", o_re, 0); chk("mid_rst_we", o_we, 0);
        chk("mid_rst_grant", o_grant, 0); chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ack", o_ack, 0); chk("mid_rst_rdata", o_rdata, 0);
        reset = 1'b1;
        ptr_m[0] = 0; ptr_m[1] = 0; rdata_m[0] = '0; rdata_m[1] = '0;
        run_txn(3'b010, 3'b010, {$urandom, 16'($urandom)}, 24'($urandom), 8'h5A, 1'b0, 0);

        for (int i = 0; i < 15; i++) begin
            rq = 3'($urandom_range(1, 7));
            run_txn(rq, 3'($urandom), {$urandom, 16'($urandom)}, 24'($urandom), 8'($urandom), 1'b1, 0);
        end

        // Round-robin instance: all three held, expected order 0,1,2,0.
        sel = 1;
        for (int i = 0; i < 4; i++)
            run_txn(3'b111, 3'($urandom), {$urandom, 16'($urandom)}, 24'($urandom), 8'($urandom), 1'b0, 0);

        // Timeout on a read with ready held low, then ready rising at cycle 3.
        run_txn(3'b001, 3'b001, {$urandom, 16'($urandom)}, 24'($urandom), 8'h77, 1'b0, 100);
        run_txn(3'b001, 3'b001, {$urandom, 16'($urandom)}, 24'($urandom), 8'h42, 1'b0, 3);

        for (int i = 0; i < 15; i++) begin
            rq = 3'($urandom_range(1, 7));
            run_txn(rq, 3'($urandom), {$urandom, 16'($urandom)}, 24'($urandom), 8'($urandom), 1'b1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
